// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / mul-div controller.
package hazard_pkg;

  localparam int unsigned CNT_W          = 6;
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF = 33;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Per-stage enables and NOP-insert controls driven to the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
  } pipe_ctrl_t;

  // Held in reset: nothing advances, every stage register is loaded with a NOP.
  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b1};

  // Exception / eret: everything advances, IF/ID/EX contents are killed.
  localparam pipe_ctrl_t CTRL_FLUSH = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b1};

  // Mul/div occupying EX: freeze front end, drain bubbles into MEM.
  localparam pipe_ctrl_t CTRL_MULDIV = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b1};

  // Taken branch: squash the two wrong-path instructions behind it.
  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};

  // Load-use: hold IF and ID, send a bubble into EX.
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0};

  // Counter load value on acceptance: the IDLE cycle and the release cycle are
  // not counted, so an N-cycle operation loads N-2.
  function automatic logic [CNT_W-1:0] start_cnt(input logic [CNT_W-1:0] n);
    start_cnt = n - CNT_W'(2);
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Iterative mul/div sequencer: holds EX for N-1 cycles, strobes HI/LO write on release.
module muldiv_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic ms_c,
  output logic hilo_we_c,
  output logic busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_sel;

  assign n_sel = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update, stall request and completion strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ms_c      = 1'b0;
    hilo_we_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_sel == CNT_W'(1)) begin
            hilo_we_c = 1'b1;
          end else begin
            ms_c    = 1'b1;
            cnt_d   = start_cnt(n_sel);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          ms_c  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hilo_we_c = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase

    // Exception/eret kills the instruction in EX: no result is written.
    if (abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      ms_c      = 1'b0;
      hilo_we_c = 1'b0;
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority merge of flush, mul/div, branch and load-use.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_use_stall,
  input  logic branch_taken_ex,
  input  logic flush_all,
  input  logic muldiv_start_ex,
  input  logic is_div_ex,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic ex_mem_bubble,
  output logic hilo_we,
  output logic muldiv_busy
);

  logic       ms_c;
  logic       seq_hilo_we_c;
  pipe_ctrl_t ctrl_c;

  muldiv_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (muldiv_start_ex),
    .is_div    (is_div_ex),
    .abort     (flush_all),
    .ms_c      (ms_c),
    .hilo_we_c (seq_hilo_we_c),
    .busy      (muldiv_busy)
  );

  // Strict-priority select of the stage controls; reset overrides everything.
  always_comb begin
    ctrl_c = CTRL_RUN;
    if (!rst_n) begin
      ctrl_c = CTRL_RESET;
    end else if (flush_all) begin
      ctrl_c = CTRL_FLUSH;
    end else if (ms_c) begin
      ctrl_c = CTRL_MULDIV;
    end else if (branch_taken_ex) begin
      ctrl_c = CTRL_BRANCH;
    end else if (load_use_stall) begin
      ctrl_c = CTRL_LOAD_USE;
    end
  end

  assign pc_en         = ctrl_c.pc_en;
  assign if_id_en      = ctrl_c.if_id_en;
  assign id_ex_en      = ctrl_c.id_ex_en;
  assign ex_mem_en     = ctrl_c.ex_mem_en;
  assign if_id_flush   = ctrl_c.if_id_flush;
  assign id_ex_flush   = ctrl_c.id_ex_flush;
  assign ex_mem_bubble = ctrl_c.ex_mem_bubble;
  // A single-cycle op seen while held in reset must not write HI/LO.
  assign hilo_we       = rst_n & seq_hilo_we_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MUL=4/DIV=33 and MUL=1/DIV=3) vs. a cycle-count model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n, load_use_stall, branch_taken_ex, flush_all, muldiv_start_ex, is_div_ex;

  logic pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, if_id_flush0, id_ex_flush0, ex_mem_bubble0, hilo_we0, busy0;
  logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, if_id_flush1, id_ex_flush1, ex_mem_bubble1, hilo_we1, busy1;

  int checks = 0;
  int errors = 0;

  // Model: cycles the operation still owns EX, counting the current cycle (0 = idle).
  int left0 = 0;
  int left1 = 0;

  localparam int M0 = 4, D0 = 33, M1 = 1, D1 = 3;
  localparam logic [8:0] RESET_VEC = 9'b0000_111_0_0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(M0), .DIV_CYCLES(D0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
    .flush_all(flush_all), .muldiv_start_ex(muldiv_start_ex), .is_div_ex(is_div_ex),
    .pc_en(pc_en0), .if_id_en(if_id_en0), .id_ex_en(id_ex_en0), .ex_mem_en(ex_mem_en0),
    .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0), .ex_mem_bubble(ex_mem_bubble0),
    .hilo_we(hilo_we0), .muldiv_busy(busy0));

  hazard_ctrl #(.MUL_CYCLES(M1), .DIV_CYCLES(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
    .flush_all(flush_all), .muldiv_start_ex(muldiv_start_ex), .is_div_ex(is_div_ex),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1),
    .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .ex_mem_bubble(ex_mem_bubble1),
    .hilo_we(hilo_we1), .muldiv_busy(busy1));

  wire [8:0] o0 = {pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, if_id_flush0, id_ex_flush0, ex_mem_bubble0, hilo_we0, busy0};
  wire [8:0] o1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, if_id_flush1, id_ex_flush1, ex_mem_bubble1, hilo_we1, busy1};

  // Expected outputs from the current inputs and the remaining-cycle count.
  function automatic logic [8:0] model(input int left, input int mul_n, input int div_n);
    int   n;
    logic stall, done, busy;
    n     = is_div_ex ? div_n : mul_n;
    busy  = (left > 0);
    stall = 1'b0;
    done  = 1'b0;
    if (left > 1)                 stall = 1'b1;
    else if (left == 1)           done  = 1'b1;
    else if (muldiv_start_ex) begin
      if (n == 1) done = 1'b1;
      else        stall = 1'b1;
    end
    if (!rst_n)               return RESET_VEC;
    else if (flush_all)       return {4'b1111, 3'b111, 1'b0, busy};
    else if (stall)           return {4'b0001, 3'b001, 1'b0, busy};
    else if (branch_taken_ex) return {4'b1111, 3'b110, done, busy};
    else if (load_use_stall)  return {4'b0011, 3'b010, done, busy};
    else                      return {4'b1111, 3'b000, done, busy};
  endfunction

  function automatic int next_left(input int left, input int mul_n, input int div_n);
    int n;
    n = is_div_ex ? div_n : mul_n;
    if (!rst_n || flush_all) return 0;
    if (left > 0)            return left - 1;
    if (muldiv_start_ex && n >= 2) return n - 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left0 = 0;
      left1 = 0;
    end else begin
      left0 = next_left(left0, M0, D0);
      left1 = next_left(left1, M1, D1);
    end
  end

  task automatic drive(input logic r, input logic f, input logic b, input logic l,
                       input logic s, input logic d);
    rst_n = r; flush_all = f; branch_taken_ex = b; load_use_stall = l;
    muldiv_start_ex = s; is_div_ex = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    checks++;
    if (o0 !== RESET_VEC) begin errors++; $display("FAIL reset inst0 got %b exp %b", o0, RESET_VEC); end
    checks++;
    if (o1 !== RESET_VEC) begin errors++; $display("FAIL reset inst1 got %b exp %b", o1, RESET_VEC); end
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (o0 !== 9'b1111_000_0_0) begin errors++; $display("FAIL reset_release got %b exp %b", o0, 9'b1111_000_0_0); end
    next_cycle();
  endtask

  task automatic test_mult();
    logic [8:0] e0, e1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      e0 = model(left0, M0, D0);
      e1 = model(left1, M1, D1);
      checks++;
      if (o0 !== e0) begin errors++; $display("FAIL mult c%0d inst0 got %b exp %b", c, o0, e0); end
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL mult c%0d inst1 got %b exp %b", c, o1, e1); end
      checks++;
      if ({pc_en0, hilo_we0, busy0} !== {c == 3, c == 3, c >= 1})
        begin errors++; $display("FAIL mult_timing c%0d got %b exp %b", c, {pc_en0, hilo_we0, busy0}, {c == 3, c == 3, c >= 1}); end
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_div_load_use();
    int stalls = 0, hilos = 0, bad_flush = 0;
    logic [8:0] e0, e1;
    for (int c = 0; c < 33; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      e0 = model(left0, M0, D0);
      e1 = model(left1, M1, D1);
      checks++;
      if (o0 !== e0) begin errors++; $display("FAIL div_lu c%0d inst0 got %b exp %b", c, o0, e0); end
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL div_lu c%0d inst1 got %b exp %b", c, o1, e1); end
      if (!pc_en0 && !id_ex_en0 && ex_mem_bubble0) begin
        stalls++;
        if (id_ex_flush0) bad_flush++;
      end
      if (hilo_we0) hilos++;
      next_cycle();
    end
    checks++;
    if (stalls != 32) begin errors++; $display("FAIL div_stall_count got %0d exp 32", stalls); end
    checks++;
    if (bad_flush != 0) begin errors++; $display("FAIL div_id_ex_flush got %0d exp 0", bad_flush); end
    checks++;
    if (hilos != 1) begin errors++; $display("FAIL div_hilo_count got %0d exp 1", hilos); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({pc_en0, id_ex_flush0, busy0} !== 3'b010)
      begin errors++; $display("FAIL div_then_lu got %b exp 010", {pc_en0, id_ex_flush0, busy0}); end
    next_cycle();
  endtask

  task automatic test_branch_load_use();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({if_id_flush0, id_ex_flush0, pc_en0, if_id_en0} !== 4'b1111)
      begin errors++; $display("FAIL branch_lu got %b exp 1111", {if_id_flush0, id_ex_flush0, pc_en0, if_id_en0}); end
    checks++;
    if (o1 !== model(left1, M1, D1)) begin errors++; $display("FAIL branch_lu inst1 got %b exp %b", o1, model(left1, M1, D1)); end
    next_cycle();
  endtask

  task automatic test_flush_mid_div();
    int hilos = 0;
    logic [8:0] e0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, c == 5, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      e0 = model(left0, M0, D0);
      checks++;
      if (o0 !== e0) begin errors++; $display("FAIL flush c%0d inst0 got %b exp %b", c, o0, e0); end
      if (hilo_we0) hilos++;
      next_cycle();
    end
    checks++;
    if ({if_id_flush0, id_ex_flush0, ex_mem_bubble0} !== 3'b111 && 1'b0)
      begin errors++; end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if (hilo_we0) hilos++;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy0); end
    checks++;
    if (hilos != 0) begin errors++; $display("FAIL flush_hilo got %0d exp 0", hilos); end
    next_cycle();
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy0); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o0 !== RESET_VEC) begin errors++; $display("FAIL async_reset inst0 got %b exp %b", o0, RESET_VEC); end
    checks++;
    if (o1 !== RESET_VEC) begin errors++; $display("FAIL async_reset inst1 got %b exp %b", o1, RESET_VEC); end
    @(negedge clk);
    #2;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({hilo_we1, pc_en1, busy1} !== 3'b110)
      begin errors++; $display("FAIL mult1_after_reset got %b exp 110", {hilo_we1, pc_en1, busy1}); end
    checks++;
    if ({busy0, pc_en0, hilo_we0} !== 3'b000)
      begin errors++; $display("FAIL mult4_after_reset got %b exp 000", {busy0, pc_en0, hilo_we0}); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
  endtask

  task automatic test_random();
    logic [8:0] e0, e1;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0);
      @(negedge clk);
      e0 = model(left0, M0, D0);
      e1 = model(left1, M1, D1);
      checks++;
      if (o0 !== e0) begin errors++; $display("FAIL random c%0d inst0 got %b exp %b", c, o0, e0); end
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL random c%0d inst1 got %b exp %b", c, o1, e1); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_load_use();
    test_branch_load_use();
    test_flush_mid_div();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
